// File: rtl/rsff_stim_chk.sv
// ----------------------------------------------------------------------------
// rsff_stim_chk
//
// Stimulus generator and lockstep checker for a set/reset flip-flop cell with
// asynchronous reset and set (reset has priority). A 16-bit Galois LFSR
// produces one vector per cycle on dut_d/dut_set/dut_reset; a reference model
// predicts the cell's q, and every pre-edge sample of dut_q is compared to it.
//
// Ports:
//   clk            sole clock, rising edge
//   reset_n        asynchronous active-low reset
//   start          begin a run (honoured in IDLE and DONE only)
//   dut_d          registered data to the cell
//   dut_set        registered async set to the cell, active-high
//   dut_reset      registered async reset to the cell, active-high
//   dut_q          cell output being checked
//   busy           high while vectors are running
//   done           high once a run has finished
//   pass           done with zero mismatches
//   err_count      saturating mismatch count
//   first_err_idx  vector index of the first mismatch (valid if err_count!=0)
// ----------------------------------------------------------------------------
module rsff_stim_chk #(
    parameter int unsigned N_VECTORS = 256,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned ERR_W     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             dut_d,
    output logic             dut_set,
    output logic             dut_reset,
    input  logic             dut_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      first_err_idx
);

    localparam logic [15:0]      LFSR_MASK = 16'hB400;
    localparam logic [15:0]      LAST_IDX  = 16'(N_VECTORS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef struct packed {
        logic rst;
        logic set;
        logic d;
    } vec_t;

    // Vector k is a pure function of the LFSR value; vector 0 always resets
    // so the cell's q is defined before any comparison relies on it.
    function automatic vec_t make_vec(input logic [15:0] l, input logic first);
        vec_t v;
        v.rst = first | (l[3:0] == 4'd0);
        v.set = (l[7:4] == 4'd0);
        v.d   = l[8];
        return v;
    endfunction

    state_e           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [15:0]      idx_q, idx_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [15:0]      first_err_idx_q, first_err_idx_d;
    logic             exp_reg_q, exp_reg_d;
    vec_t             vec_q, vec_d;

    logic             exp_now;
    logic             mismatch;
    logic [15:0]      lfsr_step;

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d         = state_q;
        lfsr_d          = lfsr_q;
        idx_d           = idx_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        exp_reg_d       = exp_reg_q;
        vec_d           = vec_q;

        // Settled pre-edge q of a healthy cell given the vector now driven.
        exp_now   = vec_q.rst ? 1'b0 : (vec_q.set ? 1'b1 : exp_reg_q);
        // NOTE: case inequality so an X or Z on the cell output is an error.
        mismatch  = (dut_q !== exp_now);
        lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    lfsr_d      = LFSR_SEED;
                    idx_d       = 16'd0;
                    err_count_d = '0;
                    vec_d       = make_vec(LFSR_SEED, 1'b1);
                end
            end
            RUN: begin
                exp_reg_d = vec_q.rst ? 1'b0 : (vec_q.set ? 1'b1 : vec_q.d);
                if (mismatch) begin
                    if (err_count_q != ERR_MAX) err_count_d = err_count_q + 1'b1;
                    if (err_count_q == '0)      first_err_idx_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    vec_d   = '0;
                end else begin
                    idx_d  = idx_q + 16'd1;
                    lfsr_d = lfsr_step;
                    vec_d  = make_vec(lfsr_step, 1'b0);
                end
            end
            default: begin
                state_d = IDLE;
                vec_d   = '0;
            end
        endcase
    end

    // NOTE: non-blocking assignments for all state so every flop samples the
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            lfsr_q          <= LFSR_SEED;
            idx_q           <= 16'd0;
            err_count_q     <= '0;
            first_err_idx_q <= 16'd0;
            exp_reg_q       <= 1'b0;
            vec_q           <= '0;
        end else begin
            state_q         <= state_d;
            lfsr_q          <= lfsr_d;
            idx_q           <= idx_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            exp_reg_q       <= exp_reg_d;
            vec_q           <= vec_d;
        end
    end

    // Outputs decode registers only; dut_q never reaches an output
    // combinationally.
    assign dut_d         = vec_q.d;
    assign dut_set       = vec_q.set;
    assign dut_reset     = vec_q.rst;
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign pass          = done && (err_count_q == '0);
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_rsff_stim_chk.sv
// ----------------------------------------------------------------------------
// tb_rsff_stim_chk
//
// Four checker instances share the clock and reset:
//   u_main  defaults, healthy reset-priority cell
//   u_one   N_VECTORS=1, cell output tied high
//   u_sat   N_VECTORS=8, ERR_W=2, inverted healthy cell
//   u_pri   N_VECTORS=8, seed 16'h181B, set-priority cell; with that seed
//           vector 5 is the first to carry both set and reset.
// ----------------------------------------------------------------------------
module tb_rsff_stim_chk;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    // ---------------- u_main ----------------
    logic        m_start, m_d, m_set, m_rst, m_q, m_busy, m_done, m_pass;
    logic [7:0]  m_err;
    logic [15:0] m_first;
    logic        m_cell_reg;

    rsff_stim_chk u_main (
        .clk(clk), .reset_n(reset_n), .start(m_start),
        .dut_d(m_d), .dut_set(m_set), .dut_reset(m_rst), .dut_q(m_q),
        .busy(m_busy), .done(m_done), .pass(m_pass),
        .err_count(m_err), .first_err_idx(m_first)
    );

    always @(posedge clk) m_cell_reg <= m_rst ? 1'b0 : (m_set ? 1'b1 : m_d);
    assign m_q = m_rst ? 1'b0 : (m_set ? 1'b1 : m_cell_reg);

    // ---------------- u_one ----------------
    logic        o_start, o_d, o_set, o_rst, o_busy, o_done, o_pass;
    logic [7:0]  o_err;
    logic [15:0] o_first;

    rsff_stim_chk #(.N_VECTORS(1)) u_one (
        .clk(clk), .reset_n(reset_n), .start(o_start),
        .dut_d(o_d), .dut_set(o_set), .dut_reset(o_rst), .dut_q(1'b1),
        .busy(o_busy), .done(o_done), .pass(o_pass),
        .err_count(o_err), .first_err_idx(o_first)
    );

    // ---------------- u_sat ----------------
    logic        s_start, s_d, s_set, s_rst, s_q, s_busy, s_done, s_pass;
    logic [1:0]  s_err;
    logic [15:0] s_first;
    logic        s_cell_reg;

    rsff_stim_chk #(.N_VECTORS(8), .ERR_W(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .start(s_start),
        .dut_d(s_d), .dut_set(s_set), .dut_reset(s_rst), .dut_q(s_q),
        .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_count(s_err), .first_err_idx(s_first)
    );

    always @(posedge clk) s_cell_reg <= s_rst ? 1'b0 : (s_set ? 1'b1 : s_d);
    assign s_q = ~(s_rst ? 1'b0 : (s_set ? 1'b1 : s_cell_reg));

    // ---------------- u_pri ----------------
    logic        p_start, p_d, p_set, p_rst, p_q, p_busy, p_done, p_pass;
    logic [7:0]  p_err;
    logic [15:0] p_first;
    logic        p_cell_reg;

    rsff_stim_chk #(.N_VECTORS(8), .LFSR_SEED(16'h181B)) u_pri (
        .clk(clk), .reset_n(reset_n), .start(p_start),
        .dut_d(p_d), .dut_set(p_set), .dut_reset(p_rst), .dut_q(p_q),
        .busy(p_busy), .done(p_done), .pass(p_pass),
        .err_count(p_err), .first_err_idx(p_first)
    );

    always @(posedge clk) p_cell_reg <= p_set ? 1'b1 : (p_rst ? 1'b0 : p_d);
    assign p_q = p_set ? 1'b1 : (p_rst ? 1'b0 : p_cell_reg);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts further negedges on which u_main stays busy; bounded.
    task automatic wait_main_idle(inout int n);
        while (m_busy === 1'b1 && n < 1000) begin
            @(negedge clk);
            if (m_busy === 1'b1) n++;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++; if (m_busy !== 1'b0)   begin errors++; $display("FAIL rst_busy: got %b want 0", m_busy); end
        checks++; if (m_done !== 1'b0)   begin errors++; $display("FAIL rst_done: got %b want 0", m_done); end
        checks++; if (m_pass !== 1'b0)   begin errors++; $display("FAIL rst_pass: got %b want 0", m_pass); end
        checks++; if (m_err !== 8'd0)    begin errors++; $display("FAIL rst_err: got %0d want 0", m_err); end
        checks++; if (m_first !== 16'd0) begin errors++; $display("FAIL rst_first: got %0d want 0", m_first); end
        checks++; if ({m_rst, m_set, m_d} !== 3'b000)
            begin errors++; $display("FAIL rst_vec: got %b want 000", {m_rst, m_set, m_d}); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (m_busy !== 1'b0 || m_done !== 1'b0)
            begin errors++; $display("FAIL idle_hold: got busy=%b done=%b want 0 0", m_busy, m_done); end
    endtask

    task automatic test_main_run;
        int n;
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        // Seed ACE1 -> vector 0 {rst,set,d}=100, L1=E270 -> 100, L2=7138 -> 001.
        checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL run_busy: got %b want 1", m_busy); end
        checks++; if ({m_rst, m_set, m_d} !== 3'b100)
            begin errors++; $display("FAIL run_v0: got %b want 100", {m_rst, m_set, m_d}); end
        @(negedge clk);
        checks++; if ({m_rst, m_set, m_d} !== 3'b100)
            begin errors++; $display("FAIL run_v1: got %b want 100", {m_rst, m_set, m_d}); end
        @(negedge clk);
        checks++; if ({m_rst, m_set, m_d} !== 3'b001)
            begin errors++; $display("FAIL run_v2: got %b want 001", {m_rst, m_set, m_d}); end
        n = 3;
        wait_main_idle(n);
        checks++; if (n != 256) begin errors++; $display("FAIL run_cycles: got %0d want 256", n); end
        checks++; if (m_done !== 1'b1) begin errors++; $display("FAIL run_done: got %b want 1", m_done); end
        checks++; if (m_pass !== 1'b1) begin errors++; $display("FAIL run_pass: got %b want 1", m_pass); end
        checks++; if (m_err !== 8'd0)  begin errors++; $display("FAIL run_err: got %0d want 0", m_err); end
        checks++; if ({m_rst, m_set, m_d} !== 3'b000)
            begin errors++; $display("FAIL done_vec: got %b want 000", {m_rst, m_set, m_d}); end
    endtask

    task automatic test_start_held;
        int n;
        m_start = 1'b1;
        @(negedge clk);
        n = 1;
        wait_main_idle(n);
        checks++; if (n != 256) begin errors++; $display("FAIL held_cycles: got %0d want 256", n); end
        checks++; if (m_done !== 1'b1) begin errors++; $display("FAIL held_done: got %b want 1", m_done); end
        @(negedge clk);
        checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL held_restart: got %b want 1", m_busy); end
        checks++; if ({m_rst, m_set, m_d} !== 3'b100)
            begin errors++; $display("FAIL held_v0: got %b want 100", {m_rst, m_set, m_d}); end
        @(negedge clk);
        @(negedge clk);
        m_start = 1'b0;
        checks++; if ({m_rst, m_set, m_d} !== 3'b001)
            begin errors++; $display("FAIL held_v2: got %b want 001", {m_rst, m_set, m_d}); end
        n = 3;
        wait_main_idle(n);
        checks++; if (n != 256) begin errors++; $display("FAIL held_cycles2: got %0d want 256", n); end
        checks++; if (m_pass !== 1'b1) begin errors++; $display("FAIL held_pass: got %b want 1", m_pass); end
    endtask

    task automatic test_reset_midrun;
        int n;
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        repeat (100) @(negedge clk);
        checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", m_busy); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({m_busy, m_done, m_pass} !== 3'b000)
            begin errors++; $display("FAIL mid_status: got %b want 000", {m_busy, m_done, m_pass}); end
        checks++; if ({m_rst, m_set, m_d} !== 3'b000)
            begin errors++; $display("FAIL mid_vec: got %b want 000", {m_rst, m_set, m_d}); end
        checks++; if (m_err !== 8'd0 || m_first !== 16'd0)
            begin errors++; $display("FAIL mid_counts: got err=%0d first=%0d want 0 0", m_err, m_first); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL mid_idle: got %b want 0", m_busy); end
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        n = 1;
        wait_main_idle(n);
        checks++; if (n != 256) begin errors++; $display("FAIL mid_cycles: got %0d want 256", n); end
        checks++; if (m_pass !== 1'b1) begin errors++; $display("FAIL mid_pass: got %b want 1", m_pass); end
    endtask

    task automatic test_single_vector;
        o_start = 1'b1;
        @(negedge clk);
        o_start = 1'b0;
        checks++; if (o_busy !== 1'b1 || {o_rst, o_set, o_d} !== 3'b100)
            begin errors++; $display("FAIL one_v0: got busy=%b vec=%b want 1 100", o_busy, {o_rst, o_set, o_d}); end
        @(negedge clk);
        checks++; if (o_done !== 1'b1 || o_busy !== 1'b0)
            begin errors++; $display("FAIL one_done: got done=%b busy=%b want 1 0", o_done, o_busy); end
        checks++; if (o_err !== 8'd1)    begin errors++; $display("FAIL one_err: got %0d want 1", o_err); end
        checks++; if (o_first !== 16'd0) begin errors++; $display("FAIL one_first: got %0d want 0", o_first); end
        checks++; if (o_pass !== 1'b0)   begin errors++; $display("FAIL one_pass: got %b want 0", o_pass); end
    endtask

    task automatic test_saturate;
        int guard;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        @(negedge clk);
        checks++; if (s_err !== 2'd1) begin errors++; $display("FAIL sat_err1: got %0d want 1", s_err); end
        @(negedge clk);
        checks++; if (s_err !== 2'd2) begin errors++; $display("FAIL sat_err2: got %0d want 2", s_err); end
        guard = 0;
        while (s_done !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++; if (s_done !== 1'b1 || s_busy !== 1'b0)
            begin errors++; $display("FAIL sat_done: got done=%b busy=%b want 1 0", s_done, s_busy); end
        checks++; if (s_err !== 2'd3)    begin errors++; $display("FAIL sat_err: got %0d want 3", s_err); end
        checks++; if (s_first !== 16'd0) begin errors++; $display("FAIL sat_first: got %0d want 0", s_first); end
        checks++; if (s_pass !== 1'b0)   begin errors++; $display("FAIL sat_pass: got %b want 0", s_pass); end
    endtask

    task automatic test_priority;
        int guard;
        p_start = 1'b1;
        @(negedge clk);
        p_start = 1'b0;
        // Seed 181B: L1..L5 = B80D E806 7403 8E01 F300; only vector 5 has both.
        repeat (5) @(negedge clk);
        checks++; if (p_err !== 8'd0) begin errors++; $display("FAIL pri_err_pre: got %0d want 0", p_err); end
        checks++; if ({p_rst, p_set} !== 2'b11)
            begin errors++; $display("FAIL pri_v5: got %b want 11", {p_rst, p_set}); end
        @(negedge clk);
        checks++; if (p_err !== 8'd1) begin errors++; $display("FAIL pri_err_v5: got %0d want 1", p_err); end
        guard = 0;
        while (p_done !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++; if (p_done !== 1'b1 || p_busy !== 1'b0)
            begin errors++; $display("FAIL pri_done: got done=%b busy=%b want 1 0", p_done, p_busy); end
        checks++; if (p_first !== 16'd5) begin errors++; $display("FAIL pri_first: got %0d want 5", p_first); end
        checks++; if (p_err !== 8'd1)    begin errors++; $display("FAIL pri_err: got %0d want 1", p_err); end
        checks++; if (p_pass !== 1'b0)   begin errors++; $display("FAIL pri_pass: got %b want 0", p_pass); end
    endtask

    initial begin
        reset_n = 1'b0;
        m_start = 1'b0;
        o_start = 1'b0;
        s_start = 1'b0;
        p_start = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_main_run();
        test_start_held();
        test_reset_midrun();
        test_single_vector();
        test_saturate();
        test_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rsff_stim_chk.md
# rsff_stim_chk

Self-checking stimulus generator and lockstep checker for the sequential techmap tests. It drives `d`/`set`/`reset` into a mapped set/reset flip-flop cell (async reset and set, reset has priority) and samples that cell's `q`. An internal reference model predicts `q`, and the block counts mismatches. It sits directly upstream (stimulus) and downstream (check) of the flip-flop under test in every techmap simulation bench for that cell family.

## Interface
Parameters:
- `N_VECTORS`, 256: vectors per run, 1..65535.
- `LFSR_SEED`, 16'hACE1: nonzero LFSR seed, reloaded on every start.
- `ERR_W`, 8: width of the saturating mismatch counter.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE and DONE.
- `dut_d`  out  1  data to the cell under test; registered.
- `dut_set`  out  1  async set to the cell, active-high; registered.
- `dut_reset`  out  1  async reset to the cell, active-high; registered.
- `dut_q`  in  1  cell output.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  `done && err_count==0`.
- `err_count`  out  ERR_W  mismatches, saturating at 2^ERR_W-1.
- `first_err_idx`  out  16  vector index of the first mismatch; meaningful only when `err_count!=0`.

## Operation
- FSM states:
  - IDLE: on `start`, go to RUN.
  - RUN: after the compare of vector N_VECTORS-1, go to DONE.
  - DONE: on `start`, go to RUN (restart).
  - `start` is ignored in RUN.
- Entering RUN:
  - `idx` clears to 0 and `err_count` clears to 0.
  - The LFSR loads `LFSR_SEED`; vector 0 goes on the outputs the same edge.
- LFSR: 16-bit Galois generator, mask 16'hB400 (x^16+x^14+x^13+x^11+1). It shifts right once per vector.
- Vector k is derived from the current LFSR value L:
  - `dut_reset = (k==0) | (L[3:0]==0)`. Vector 0 always resets so `q` is defined.
  - `dut_set = (L[7:4]==0)`.
  - `dut_d = L[8]`.
- Reference model:
  - `exp_now = dut_reset ? 0 : dut_set ? 1 : exp_reg`, combinational on the current outputs.
  - At each RUN edge: `exp_reg <= dut_reset ? 0 : dut_set ? 1 : dut_d`.
  - Reset beats set, matching the cell's priority.
- Compare, at each RUN edge, before the outputs advance:
  - A mismatch is `dut_q !== exp_now`. Case inequality is used, so X or Z on `dut_q` counts as an error.
  - On a mismatch, `err_count` increments, saturating.
  - If `err_count` was 0, `first_err_idx <= idx`.
- DONE: `dut_d`, `dut_set` and `dut_reset` are driven to 0; `err_count` and `first_err_idx` hold.
- Reset values (`reset_n` low, at any time including mid-run):
  - FSM = IDLE; all `dut_*` = 0.
  - `busy`, `done`, `pass` = 0; `err_count` = 0; `first_err_idx` = 0.
  - LFSR = `LFSR_SEED`; `exp_reg` = 0.
  - The run is abandoned; no partial result survives.

## Timing
- `start` high at edge t0 (in IDLE or DONE):
  - `busy` = 1 and vector 0 is on `dut_*` after t0.
- Vector k is driven during cycle (tk, tk+1]; the compare is at edge tk+1, and vector k+1 is driven from that same edge.
- The cell's async set/reset act within the driving cycle, and its clocked capture of `dut_d` lands at tk+1. The compare at tk+1 therefore sees the settled pre-edge `q`.
- Latency and status:
  - The last compare is at edge tN.
  - `busy` falls and `done` rises at tN.
  - `err_count` and `pass` are final from tN.
  - A run occupies exactly N_VECTORS cycles.
- All outputs are registered; there is no combinational path from `dut_q` to any output.

## Test plan
- Healthy cell, defaults, one `start` pulse -> `busy` high for exactly 256 cycles; then `done`=1, `pass`=1, `err_count`=0.
- N_VECTORS=1, `dut_q` tied 1 -> after 1 cycle `done`=1, `err_count`=1, `first_err_idx`=0, `pass`=0.
- ERR_W=2, `dut_q` = inverted healthy `q` -> `err_count` saturates at 3, `first_err_idx`=0, `pass`=0.
- Cell variant with set priority over reset, LFSR_SEED chosen so that vector 5 has both `set` and `reset` high -> `first_err_idx`=5, `pass`=0.
- `reset_n` pulsed low at vector 100 -> all outputs 0 asynchronously, FSM IDLE; a new `start` then runs 256 fresh vectors and passes.
- `start` held high throughout RUN -> no restart; `done` at cycle 256, then an immediate restart from DONE with identical vectors (LFSR reseeded).
